mem_arbiter: RTL and testbench

//  Shares one unified instruction/data memory between the fetch port (PC side) and the load/store

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between the fetch port and the load/store port.
// Optional build macro MEM_FAULT_EN: misaligned grants skip the access and return a fault.
module mem_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic        dm_unsigned,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_fault,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_reg;
  logic [LW-1:0] lat_cnt_reg;
  logic [SW-1:0] starve_cnt_reg;
  logic          owner_dm_reg;
  logic          we_reg;
  logic [1:0]    mem_size_reg;
  logic          mem_unsigned_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic          if_valid_reg;
  logic          dm_valid_reg;
  logic          if_fault_reg;
  logic          dm_fault_reg;
  logic [31:0]   if_rdata_reg;
  logic [31:0]   dm_rdata_reg;

  logic idle;
  logic force_fetch;
  logic if_misaligned;
  logic dm_misaligned;
  logic grant_fault;

  assign idle        = (state_reg == IDLE);
  assign force_fetch = (STARVE_LIMIT != 0) && (starve_cnt_reg == STARVE_MAX);

  // No grant can be taken while reset is held, even though the state reads IDLE.
  assign dm_gnt = idle & reset & dm_req & ~(if_req & force_fetch);
  assign if_gnt = idle & reset & if_req & ~dm_gnt;

`ifdef MEM_FAULT_EN
  assign if_misaligned = |if_addr[1:0];
  assign dm_misaligned = (dm_size == 2'b01) ? dm_addr[0] :
                         (dm_size[1]        ? |dm_addr[1:0] : 1'b0);
`else
  assign if_misaligned = 1'b0;
  assign dm_misaligned = 1'b0;
`endif

  assign grant_fault = (if_gnt & if_misaligned) | (dm_gnt & dm_misaligned);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      lat_cnt_reg      <= '0;
      starve_cnt_reg   <= '0;
      owner_dm_reg     <= 1'b0;
      we_reg           <= 1'b0;
      mem_size_reg     <= 2'b00;
      mem_unsigned_reg <= 1'b0;
      mem_addr_reg     <= 32'h0;
      mem_wdata_reg    <= 32'h0;
      if_valid_reg     <= 1'b0;
      dm_valid_reg     <= 1'b0;
      if_fault_reg     <= 1'b0;
      dm_fault_reg     <= 1'b0;
      if_rdata_reg     <= 32'h0;
      dm_rdata_reg     <= 32'h0;
    end else begin
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
      if_fault_reg <= 1'b0;
      dm_fault_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            owner_dm_reg     <= dm_gnt;
            mem_addr_reg     <= dm_gnt ? dm_addr : if_addr;
            we_reg           <= dm_gnt & dm_we;
            mem_size_reg     <= dm_gnt ? dm_size : 2'b10;
            mem_unsigned_reg <= dm_gnt & dm_unsigned;
            mem_wdata_reg    <= dm_gnt ? dm_wdata : 32'h0;
            lat_cnt_reg      <= '0;
            // Only a data grant that bypassed a waiting fetch counts toward starvation.
            if (if_gnt || !if_req) begin
              starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != STARVE_MAX) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
            if (grant_fault) begin
              if (dm_gnt) begin
                dm_valid_reg <= 1'b1;
                dm_fault_reg <= 1'b1;
                dm_rdata_reg <= 32'h0;
              end else begin
                if_valid_reg <= 1'b1;
                if_fault_reg <= 1'b1;
                if_rdata_reg <= 32'h0;
              end
            end else begin
              state_reg <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt_reg == LAT_LAST) begin
            state_reg <= IDLE;
            if (owner_dm_reg) begin
              dm_valid_reg <= 1'b1;
              dm_rdata_reg <= we_reg ? 32'h0 : mem_rdata;
            end else begin
              if_valid_reg <= 1'b1;
              if_rdata_reg <= mem_rdata;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_en       = (state_reg == ACCESS);
  assign mem_we       = mem_en & we_reg;
  assign mem_size     = mem_size_reg;
  assign mem_unsigned = mem_unsigned_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign busy         = ~idle;

  assign if_valid = if_valid_reg;
  assign if_rdata = if_rdata_reg;
  assign if_fault = if_fault_reg;
  assign dm_valid = dm_valid_reg;
  assign dm_rdata = dm_rdata_reg;
  assign dm_fault = dm_fault_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a word-wide memory and a
// transaction-level reference model (grant timing, starvation count, shadow memory).
module tb_mem_arbiter;
  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_valid, if_fault;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [1:0]  dm_size = 2'b00;
  logic        dm_unsigned = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic        dm_gnt, dm_valid, dm_fault;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we, mem_unsigned, busy;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_fault(if_fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .dm_fault(dm_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: 256 words, loaded from the shadow copy while load_mem is high.
  logic [31:0] shadow  [0:255];
  logic [31:0] mem_arr [0:255];
  logic        load_mem = 1'b0;

  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= shadow[i];
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_dm(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    dm_req = 1'b1; dm_we = we; dm_size = sz; dm_unsigned = 1'b0;
    dm_addr = a; dm_wdata = wd;
  endtask

  // Reference model state for the random phase.
  int          free_at, acc_lo, acc_hi, if_due, dm_due, starve, g;
  logic [31:0] exp_if_rd, exp_dm_rd, acc_addr;
  logic        acc_we, if_pend, dm_pend, m_idle, exp_dm_g, exp_if_g, in_win;
  logic [9:0]  exp_dm_seq;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = $urandom;
    shadow[4] = 32'h00A00093;
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_valids", {if_valid, dm_valid}, 0);
    chk("reset_rdata", if_rdata | dm_rdata, 0);
    @(negedge clk); reset = 1'b1;

    // Fetch of 0x10
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    $display("fetch addr=0x10");
    chk("fetch_if_gnt", if_gnt, 1);
    chk("fetch_dm_gnt", dm_gnt, 0);
    @(negedge clk); if_req = 1'b0; #1;
    chk("fetch_mem_en_t1", mem_en, 1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_size", mem_size, 2'b10);
    chk("fetch_busy", busy, 1);
    @(negedge clk); #1;
    chk("fetch_mem_en_t2", mem_en, 1);
    chk("fetch_no_early_valid", if_valid, 0);
    @(negedge clk); #1;
    chk("fetch_valid", if_valid, 1);
    chk("fetch_rdata", if_rdata, 32'h00A00093);
    chk("fetch_mem_en_t3", mem_en, 0);
    chk("fetch_idle", busy, 0);
    @(negedge clk); #1;
    chk("fetch_valid_pulse", if_valid, 0);
    chk("fetch_rdata_hold", if_rdata, 32'h00A00093);

    // Reset in the middle of an access
    @(negedge clk); set_dm(1'b0, 2'b10, 32'h20, 32'h0); #1;
    $display("load addr=0x20 (aborted by reset)");
    chk("abort_gnt", dm_gnt, 1);
    @(negedge clk); dm_req = 1'b0; #1;
    chk("abort_mem_en_before", mem_en, 1);
    reset = 1'b0; #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("abort_no_valid", {if_valid, dm_valid}, 0);
    end
    chk("abort_rdata_cleared", if_rdata, 0);

    // Store 0xDEADBEEF to 0x100, then load it back
    @(negedge clk); set_dm(1'b1, 2'b10, 32'h100, 32'hDEADBEEF); #1;
    $display("store addr=0x100 data=0xdeadbeef");
    chk("store_gnt", dm_gnt, 1);
    @(negedge clk); dm_req = 1'b0; #1;
    chk("store_mem_we_t1", mem_we, 1);
    chk("store_mem_addr", mem_addr, 32'h100);
    chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("store_mem_we_t2", mem_we, 1);
    @(negedge clk); #1;
    chk("store_valid", dm_valid, 1);
    chk("store_rdata", dm_rdata, 0);
    shadow[8'h40] = 32'hDEADBEEF;
    @(negedge clk); set_dm(1'b0, 2'b10, 32'h100, 32'h0); #1;
    $display("load addr=0x100");
    chk("load_gnt", dm_gnt, 1);
    @(negedge clk); dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("load_valid", dm_valid, 1);
    chk("load_rdata", dm_rdata, 32'hDEADBEEF);

    // Back-to-back loads with dm_req held
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) set_dm(1'b0, 2'b10, 32'h100, 32'h0);
      if (k == 7) dm_req = 1'b0;
      #1;
      if (dm_gnt) $display("b2b load grant at offset %0d", k);
      chk($sformatf("b2b_gnt_%0d", k), dm_gnt, (k == 0 || k == 3 || k == 6));
      chk($sformatf("b2b_valid_%0d", k), dm_valid, (k == 3 || k == 6 || k == 9));
    end

    // Collision: expect dm x4, if, dm x4, if
    exp_dm_seq = 10'b0111101111;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    set_dm(1'b0, 2'b10, 32'h100, 32'h0);
    g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      #1;
      if (if_gnt || dm_gnt) begin
        $display("collision grant %0d -> %s", g, dm_gnt ? "data" : "fetch");
        chk($sformatf("collision_dm_%0d", g), dm_gnt, exp_dm_seq[g]);
        chk($sformatf("collision_if_%0d", g), if_gnt, !exp_dm_seq[g]);
        g++;
      end
      @(negedge clk);
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("collision_grant_count", g, 10);
    repeat (3) @(negedge clk);

    // Misaligned half load at 0x101
    @(negedge clk); set_dm(1'b0, 2'b01, 32'h101, 32'h0); #1;
    $display("half load addr=0x101");
    chk("half_gnt", dm_gnt, 1);
    @(negedge clk); dm_req = 1'b0; #1;
`ifdef MEM_FAULT_EN
    chk("fault_valid", dm_valid, 1);
    chk("fault_flag", dm_fault, 1);
    chk("fault_rdata", dm_rdata, 0);
    chk("fault_no_mem_en", mem_en, 0);
    chk("fault_idle", busy, 0);
`else
    chk("half_mem_en", mem_en, 1);
    chk("half_no_early_valid", dm_valid, 0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("half_valid", dm_valid, 1);
    chk("half_no_fault", dm_fault, 0);
    chk("half_rdata", dm_rdata, 32'hDEADBEEF);
`endif
    repeat (2) @(negedge clk);

    // Randomized traffic against the transaction-level model
    free_at = 0; acc_lo = -1; acc_hi = -2; if_due = -1; dm_due = -1; starve = 0;
    if_pend = 1'b0; dm_pend = 1'b0;
    exp_if_rd = 32'h0; exp_dm_rd = 32'h0; acc_addr = 32'h0; acc_we = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!if_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          if_pend = 1'b1; if_req = 1'b1;
          if_addr = 32'($urandom_range(0, 255)) << 2;
        end else begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_pend = 1'b0; if_req = 1'b0;
      end
      if (!dm_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_pend = 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            set_dm(1'b1, 2'b10, 32'($urandom_range(0, 255)) << 2, $urandom);
          end else begin
            ra = 32'($urandom_range(0, 1023));
            set_dm(1'b0, 2'($urandom_range(0, 3)), ra, 32'h0);
            if (dm_size == 2'b01) dm_addr[0] = 1'b0;
            if (dm_size[1]) dm_addr[1:0] = 2'b00;
            dm_unsigned = 1'($urandom_range(0, 1));
          end
        end else begin
          dm_req = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dm_pend = 1'b0; dm_req = 1'b0;
      end
      #1;
      m_idle   = (cyc >= free_at);
      exp_dm_g = m_idle && dm_req && !(if_req && STARVE_LIMIT != 0 && starve == STARVE_LIMIT);
      exp_if_g = m_idle && if_req && !exp_dm_g;
      in_win   = (cyc >= acc_lo) && (cyc <= acc_hi);
      chk("rand_dm_gnt", dm_gnt, exp_dm_g);
      chk("rand_if_gnt", if_gnt, exp_if_g);
      chk("rand_if_valid", if_valid, (cyc == if_due));
      chk("rand_dm_valid", dm_valid, (cyc == dm_due));
      if (cyc == if_due) begin
        chk("rand_if_rdata", if_rdata, exp_if_rd);
        chk("rand_if_fault", if_fault, 0);
      end
      if (cyc == dm_due) begin
        chk("rand_dm_rdata", dm_rdata, exp_dm_rd);
        chk("rand_dm_fault", dm_fault, 0);
      end
      chk("rand_mem_en", mem_en, in_win);
      chk("rand_busy", busy, in_win);
      if (in_win) begin
        chk("rand_mem_addr", mem_addr, acc_addr);
        chk("rand_mem_we", mem_we, acc_we);
      end
      if (exp_dm_g) begin
        acc_lo = cyc + 1; acc_hi = cyc + MEM_LAT; free_at = cyc + MEM_LAT + 1;
        dm_due = free_at; acc_addr = dm_addr; acc_we = dm_we;
        if (dm_we) begin
          shadow[dm_addr[9:2]] = dm_wdata;
          exp_dm_rd = 32'h0;
        end else begin
          exp_dm_rd = shadow[dm_addr[9:2]];
        end
        starve = if_req ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        dm_pend = 1'b0;
        $display("cyc %0d data %s addr=0x%08h", cyc, dm_we ? "store" : "load", dm_addr);
      end else if (exp_if_g) begin
        acc_lo = cyc + 1; acc_hi = cyc + MEM_LAT; free_at = cyc + MEM_LAT + 1;
        if_due = free_at; acc_addr = if_addr; acc_we = 1'b0;
        exp_if_rd = shadow[if_addr[9:2]];
        starve = 0;
        if_pend = 1'b0;
        $display("cyc %0d fetch addr=0x%08h", cyc, if_addr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
